// File: rtl/muldiv_hilo_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_unit_if
//
// Purpose
//   Bundles the EX-stage <-> multiply/divide unit signals. The EX stage drives
//   the request and mthi/mtlo side through the master modport. The unit
//   returns busy/done and the architectural HI/LO values through the slave
//   modport.
//
// Signals
//   start   request an operation (taken only while busy=0)
//   op      2'b00 mult, 2'b01 multu, 2'b10 div, 2'b11 divu
//   a, b    rs / rt operands
//   cancel  squash the operation in flight
//   hi_we   mthi write strobe
//   lo_we   mtlo write strobe
//   wdata   mthi / mtlo data
//   busy    operation in flight
//   done    one-cycle pulse when HI/LO were just written by an operation
//   hi, lo  architectural HI / LO registers
//   div0    divide-by-zero flag, pulses together with done
//           (present only when MULDIV_DIV0_FLAG_EN is defined)
//
// Configuration macro: MULDIV_DIV0_FLAG_EN
// -----------------------------------------------------------------------------
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic             div0;
`endif

  // EX-stage side
  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
`ifdef MULDIV_DIV0_FLAG_EN
    input  div0,
`endif
    input  busy, done, hi, lo
  );

  // Multiply/divide unit side
  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
`ifdef MULDIV_DIV0_FLAG_EN
    output div0,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_unit
//
// Purpose
//   Iterative MIPS mult/multu/div/divu engine that owns the architectural HI
//   and LO registers. An operation runs on unsigned magnitudes for WIDTH
//   steps. A final fix-up cycle then applies the result signs and writes
//   HI/LO. mthi/mtlo writes are served while the unit is idle. An in-flight
//   operation can be cancelled (pipeline squash).
//
//   Timeline for a normal operation that starts at edge E0:
//     E0            operands latched, busy rises
//     E1..E_WIDTH   one shift-add or restoring shift-subtract step per edge
//     E_WIDTH+1     sign fix-up, HI/LO written, busy falls, done pulses
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   muldiv_hilo_unit_if.slave (start/op/a/b/cancel/hi_we/lo_we/wdata
//         in; busy/done/hi/lo[/div0] out)
//
// Configuration macro: MULDIV_DIV0_FLAG_EN
//   When defined, a divide by zero skips the iterative phase (fix-up at E1)
//   and raises div0 together with done. When undefined, a divide by zero takes
//   the normal latency. Both builds produce the same HI/LO values.
// -----------------------------------------------------------------------------
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  muldiv_hilo_unit_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sa_q, sa_d;        // sign of a (0 for unsigned ops)
  logic             sb_q, sb_d;        // sign of b (0 for unsigned ops)
  logic             b_zero_q, b_zero_d;
  // |a| for a multiply (multiplicand), |b| for a divide (divisor)
  logic [WIDTH-1:0] opb_q, opb_d;
  // multiply: upper product half; divide: partial remainder
  logic [WIDTH-1:0] acc_q, acc_d;
  // multiply: multiplier shifting into the lower product half
  // divide:   dividend shifting out while quotient bits shift in
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
`ifdef MULDIV_DIV0_FLAG_EN
  logic             div0_q, div0_d;
`endif

  // -------------------------------------------------------------------------
  // Operand preparation for the start edge
  // -------------------------------------------------------------------------
  logic             in_signed;
  logic             in_is_div;
  logic             in_b_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // op[0] set means the unsigned flavour, op[1] set means a divide
  assign in_signed = ~bus.op[0];
  assign in_is_div = bus.op[1];
  assign in_b_zero = (bus.b == '0);
  // |MIN| wraps to MIN. That is still the correct unsigned magnitude 2^(WIDTH-1).
  assign abs_a = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // -------------------------------------------------------------------------
  // One iteration step
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  // Shift-add: add the multiplicand to the upper half when the multiplier LSB
  // is set, then shift {carry, acc, sh} right by one.
  assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);

  // Restoring division: bring the next dividend bit into the remainder and
  // subtract the divisor when it fits. The remainder stays below the divisor,
  // so the shifted value always fits in WIDTH+1 bits. A zero divisor always
  // "fits". That gives an all-ones quotient and leaves |a| in the remainder,
  // which the divide-by-zero result below relies on.
  assign div_shift = {acc_q, sh_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift - {1'b0, opb_q};

  // -------------------------------------------------------------------------
  // Sign fix-up of the raw magnitude results
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_raw = {acc_q, sh_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod_raw : prod_raw;
  assign quo_fix  = (sa_q ^ sb_q) ? -sh_q : sh_q;
  // Truncating division: the remainder takes the dividend's sign. For a divide
  // by zero, acc holds |a|, so this rebuilds the original a.
  assign rem_fix  = sa_q ? -acc_q : acc_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written in this block gets its default first. A path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    b_zero_d = b_zero_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
    div0_d   = 1'b0;
`endif

    if (bus.cancel && (state_q != S_IDLE)) begin
      // Squash: drop the operation, leave HI/LO alone, no done pulse.
      // This also takes priority over the fix-up write on the same edge.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // An mthi/mtlo write lands on this edge even when a start is taken
          // on the same edge. The operation result overwrites it at fix-up.
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;

          if (bus.start) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = in_is_div;
            sa_d     = in_signed & bus.a[WIDTH-1];
            sb_d     = in_signed & bus.b[WIDTH-1];
            b_zero_d = in_b_zero;
            opb_d    = in_is_div ? abs_b : abs_a;
            acc_d    = '0;
            sh_d     = in_is_div ? abs_a : abs_b;
`ifdef MULDIV_DIV0_FLAG_EN
            if (in_is_div && in_b_zero) begin
              // Skip the iterations. Preload what they would have produced.
              state_d = S_FIX;
              acc_d   = abs_a;
              sh_d    = '1;
            end
`endif
          end
        end

        S_RUN: begin
          if (is_div_q) begin
            acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end

        S_FIX: begin
          if (is_div_q && b_zero_q) begin
            // Divide by zero: hi = a, lo = all ones, no sign fix-up.
            hi_d = rem_fix;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d  = 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
          div0_d  = is_div_q & b_zero_q;
`endif
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register reads
  // its pre-edge value, so the order of the statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, not only the control
      // state. HI/LO are architectural and must come back as zero.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_zero_q <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      b_zero_q <= b_zero_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_q   <= div0_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
  assign bus.div0 = div0_q;
`endif

endmodule
